fsm_step_controller: RTL
========================

# fsm_step_controller

Sequential controller for the 3-bit next-state network of the lab state machine. It owns the state register and feeds the network one serial input bit per step from a parallel-loaded word. It records the network's 2-bit output for every step and reports completion with a start/done handshake. It sits between the bench or top-level and the combinational next-state block, which it drives through `s3`, `s2`, `s1` and `x` and reads back through `n3`, `n2`, `n1` and `y`.

## Interface
- `WIDTH`, 8: input bits per run, range 1..16.
- `ILLEGAL_MASK`, 8'hC0: bit k set means state code k is illegal; only used under the config macro.
- `clk` input 1: single clock, all flops on the rising edge.
- `reset` input 1: synchronous, active-high; sampled only on the rising edge of `clk`.
- `start` input 1: begin a run; sampled only in IDLE.
- `abort` input 1: cancel an active run.
- `step_mode` input 1: 0 = free-run one step per cycle; 1 = one step per `step` pulse; sampled at `start`.
- `step` input 1: advance one step in step mode.
- `word` input WIDTH: serial input bits, applied LSB first.
- `init_state` input 3: state loaded at `start`, ordered {s3,s2,s1}.
- `n3`, `n2`, `n1` input 1 each: next state from the network.
- `y` input 2: network output for the current state.
- `s3`, `s2`, `s1` output 1 each: current state register.
- `x` output 1: current serial bit; 0 outside RUN.
- `busy` output 1: high in RUN and PAUSE.
- `done` output 1: one-cycle pulse at normal completion.
- `err` output 1: sticky illegal-state flag.
- `y_log` output 2*WIDTH: per-step `y` record.
- `steps` output $clog2(WIDTH+1): number of completed steps.

## Operation
- **FSM states:** IDLE, RUN, PAUSE, DONE, ERR.
- **IDLE to RUN or PAUSE on `start`:**
  - load the shift register with `word` and the state register with `init_state`;
  - clear `y_log`, `steps` and `err`;
  - go to RUN, or to PAUSE if `step_mode` = 1.
- **Step (RUN only):**
  - `x` = shift[0], combinationally;
  - on the edge: state <= {n3,n2,n1}; y_log[2k+1:2k] <= `y` with k = `steps`; shift >>= 1; steps += 1.
  - `y` is therefore the output of the pre-update state.
- **Next state after a step:**
  - if `steps` reaches WIDTH, go to DONE;
  - else stay in RUN in free-run mode;
  - else go to PAUSE in step mode.
- **PAUSE:** `step` = 1 moves to RUN. RUN always performs exactly one step per cycle.
- **DONE:** `done` = 1 for one cycle, then IDLE. State, `y_log` and `steps` hold until the next `start`.
- **`abort` in RUN or PAUSE:**
  - go to IDLE, state <= 3'b000, no `done`;
  - `y_log` and `steps` keep their partial values;
  - `abort` has priority over a step in the same cycle.
- **`start` outside IDLE:** ignored. `start` and `abort` together in IDLE: `start` wins.
- **Width rule:** `steps` never exceeds WIDTH, and `y_log` writes never go past index WIDTH-1.

## Timing
- **Reset values:** FSM = IDLE, state = 3'b000, `x` = 0, `busy` = 0, `done` = 0, `err` = 0, `y_log` = 0, `steps` = 0.
- **Reset mid-run:** same values on the next edge; no `done`.
- **Free-run latency:** `start` at edge 0; steps at edges 1..WIDTH; `done` high in the cycle after edge WIDTH.
- **Step-mode latency:** one step per `step` pulse accepted in PAUSE, with 1-cycle latency (PAUSE to RUN to step). A `step` held high gives one step every 2 cycles.
- **`busy`:** rises the cycle after `start` and falls with the transition to DONE, ERR or IDLE.
- **Outputs:** `s3`, `s2`, `s1`, `done`, `busy`, `err`, `y_log` and `steps` are all registered; `x` is the only combinational output.

## Configuration
- **`FSMCTL_ILLEGAL_CHECK_EN` defined:**
  - in RUN, if ILLEGAL_MASK[state] = 1, no step is taken;
  - FSM goes to ERR with `err` <= 1 and `busy` low, no `done`;
  - ERR returns to IDLE next cycle, and `err` stays high until `start` or `reset`;
  - this also applies to an illegal `init_state` on the first RUN cycle.
- **Not defined:** no check; `err` is tied to 0, every state code steps normally, and ERR is unreachable.

## Test plan
- **Reset:** `reset` = 1 for 2 cycles -> all outputs at their reset values; `start` held with `reset` -> stays IDLE.
- **Free run:**
  - stimulus: `init_state` = 000, `word` = 8'b0011_0001, `step_mode` = 0, `start` pulse;
  - visited states: 001, 010, 011, 100, 101, 001, 010, 011;
  - final state 011, `steps` = 8, `y_log` = 16'h0400;
  - `done` exactly one cycle, 9 cycles after `start`.
- **Step mode:** same stimulus with `step_mode` = 1 and `step` pulses 5 cycles apart -> state changes only 2 cycles after each pulse; same final results as free run.
- **Abort:** `abort` asserted after the 3rd step -> IDLE, state 000, `steps` = 3, no `done`; `start` during the run is ignored.
- **With `FSMCTL_ILLEGAL_CHECK_EN`:** `init_state` = 110, `start` -> `err` = 1, `steps` = 0, no `done`; `err` clears on the next `start`.
- **Without the macro:** `init_state` = 110, `word` bit0 = 0 -> first `y` logged is 2'b10 and the next state is 010.

Source files
------------

// File: rtl/fsm_step_controller.sv
// fsm_step_controller: owns the 3-bit state register of the lab state machine,
// feeds the external next-state network one serial bit per step from a
// parallel-loaded word, and logs the network's 2-bit output for every step.
// Optional feature macro: FSMCTL_ILLEGAL_CHECK_EN enables the illegal-state
// trap (codes flagged in ILLEGAL_MASK send the run to ERR instead of stepping).
module fsm_step_controller #(
    parameter int         WIDTH        = 8,
    parameter logic [7:0] ILLEGAL_MASK = 8'hC0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         step_mode,
    input  logic                         step,
    input  logic [WIDTH-1:0]             word,
    input  logic [2:0]                   init_state,
    input  logic                         n3,
    input  logic                         n2,
    input  logic                         n1,
    input  logic [1:0]                   y,
    output logic                         s3,
    output logic                         s2,
    output logic                         s1,
    output logic                         x,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [2*WIDTH-1:0]           y_log,
    output logic [$clog2(WIDTH+1)-1:0]   steps
);

    localparam int SW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        PAUSE = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } fsm_t;

    fsm_t             fsm;
    fsm_t             fsm_next;
    logic [2:0]       cur_state;
    logic [WIDTH-1:0] shift;
    logic             mode;
    logic             illegal;
    logic             last_step;
    logic             do_load;
    logic             do_abort;
    logic             do_step;
    logic             do_flag;

    assign {s3, s2, s1} = cur_state;
    assign last_step    = (steps == SW'(WIDTH - 1));

`ifdef FSMCTL_ILLEGAL_CHECK_EN
    logic err_q;

    assign illegal = ILLEGAL_MASK[cur_state];
    assign err     = err_q;

    // Sticky illegal-state flag, cleared only by a new run or reset
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (do_load) begin
            err_q <= 1'b0;
        end else if (do_flag) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_ok;

    assign illegal   = 1'b0;
    assign err       = 1'b0;
    assign unused_ok = ^{ILLEGAL_MASK, do_flag};
`endif

    // Controller state register
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_next;
        end
    end

    // Next-state logic; abort beats a step, and a trapped state never steps
    always_comb begin
        fsm_next = fsm;
        unique case (fsm)
            IDLE: begin
                if (start) begin
                    fsm_next = step_mode ? PAUSE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    fsm_next = IDLE;
                end else if (illegal) begin
                    fsm_next = ERR;
                end else if (last_step) begin
                    fsm_next = DONE;
                end else if (mode) begin
                    fsm_next = PAUSE;
                end else begin
                    fsm_next = RUN;
                end
            end
            PAUSE: begin
                if (abort) begin
                    fsm_next = IDLE;
                end else if (step) begin
                    fsm_next = RUN;
                end
            end
            DONE:    fsm_next = IDLE;
            ERR:     fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    // Output decode: serial bit to the network plus datapath strobes
    always_comb begin
        x        = 1'b0;
        do_load  = 1'b0;
        do_abort = 1'b0;
        do_step  = 1'b0;
        do_flag  = 1'b0;
        if (fsm == RUN) begin
            x = shift[0];
        end
        if (fsm == IDLE && start) begin
            do_load = 1'b1;
        end
        if ((fsm == RUN || fsm == PAUSE) && abort) begin
            do_abort = 1'b1;
        end
        if (fsm == RUN && !abort && !illegal) begin
            do_step = 1'b1;
        end
        if (fsm == RUN && !abort && illegal) begin
            do_flag = 1'b1;
        end
    end

    // Datapath: load on start, park state on abort, shift and log on a step
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= 3'b000;
            shift     <= '0;
            y_log     <= '0;
            steps     <= '0;
            mode      <= 1'b0;
        end else if (do_load) begin
            cur_state <= init_state;
            shift     <= word;
            y_log     <= '0;
            steps     <= '0;
            mode      <= step_mode;
        end else if (do_abort) begin
            cur_state <= 3'b000;
        end else if (do_step) begin
            cur_state <= {n3, n2, n1};
            shift     <= shift >> 1;
            steps     <= steps + SW'(1);
            for (int k = 0; k < WIDTH; k++) begin
                if (steps == SW'(k)) begin
                    y_log[2*k +: 2] <= y;
                end
            end
        end
    end

    // Registered status flags derived from where the controller is heading
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (fsm_next == RUN) || (fsm_next == PAUSE);
            done <= (fsm_next == DONE);
        end
    end

endmodule
